nbvn_llr_accum: RTL and testbench
=================================

Name: nbvn_llr_accum

Overview:
- Serial non-binary variable-node unit for the GF(q) LDPC decoder.
- Accepts one channel LLR vector, then DV check-to-variable messages, one per handshake. Messages arrive already de-permuted by the output-reflect stage.
- Emits DV extrinsic variable-to-check vectors, normalized and saturated, directly to the LLR reflect (permutation) stage that feeds the check nodes.
- Also produces the hard-decision symbol.

Parameters:
- FIELD, 3, number of field elements per LLR vector.
- LLR_BIT, 3, signed width of each LLR element on all vector ports.
- DV, 3, variable-node degree: messages accepted and emitted per node.
- ACC_BIT, 6, signed width of each internal accumulator element.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; one clock, synchronous, active-low.
- CH_VALID  in  1  channel vector valid.
- CH_READY  out  1  high only in IDLE.
- CH_LLR  in  FIELD*LLR_BIT  channel LLR vector; element e at bits [e*LLR_BIT +: LLR_BIT], signed.
- IN_VALID  in  1  C2V message valid.
- IN_READY  out  1  high only in ACCUM.
- IN_LLR  in  FIELD*LLR_BIT  C2V message vector, same packing.
- OUT_VALID  out  1  extrinsic vector valid.
- OUT_READY  in  1  downstream accept.
- OUT_LLR  out  FIELD*LLR_BIT  extrinsic V2C vector.
- OUT_IDX  out  max(1,$clog2(DV))  edge index k of OUT_LLR.
- OUT_LAST  out  1  high with OUT_VALID when k = DV-1.
- DEC_VALID  out  1  one-cycle pulse.
- DEC_SYM  out  max(1,$clog2(FIELD))  hard-decision symbol.

Behaviour:
- LLR convention: L(a) = ln P(a)/P(0). Element 0 is the reference and is always 0 on OUT_LLR.
- Reset (RST_N low at a CLK edge) gives:
  - state IDLE;
  - accumulators, message buffer and counter cleared;
  - OUT_VALID = 0, OUT_LLR = 0, OUT_IDX = 0, OUT_LAST = 0;
  - DEC_VALID = 0, DEC_SYM = 0;
  - IN_READY = 0, CH_READY = 1 after reset.
- Reset mid-operation discards the node in progress; no partial output is produced.
- IDLE state:
  - On CH_VALID & CH_READY: ACC[e] = sign-extended CH_LLR[e]; counter = 0; go to ACCUM.
  - IN_VALID is ignored.
- ACCUM state:
  - On IN_VALID & IN_READY: buf[counter] = IN_LLR; ACC[e] = sat_ACC(ACC[e] + IN_LLR[e]); counter++.
  - On acceptance of the DVth message, go to EMIT with k = 0.
  - CH_VALID is ignored.
- Entry to EMIT:
  - DEC_VALID pulses for the first EMIT cycle.
  - DEC_SYM = argmax_e(ACC[e] - ACC[0]); ties go to the lowest index.
- EMIT state:
  - OUT_VALID = 1. OUT_IDX = k. OUT_LAST = (k == DV-1).
  - ext[e] = ACC[e] - buf[k][e], computed at width ACC_BIT+2.
  - OUT_LLR[e] = sat_LLR(ext[e] - ext[0]), where sat_LLR clamps to [-2^(LLR_BIT-1), 2^(LLR_BIT-1)-1].
  - OUT_LLR, OUT_IDX and OUT_LAST stay stable while OUT_VALID & !OUT_READY.
  - On handshake: k++. The handshake with OUT_LAST returns to IDLE; CH_READY rises the next cycle.
- Latency:
  - First OUT_VALID is the cycle after the DVth message is accepted.
  - Throughput is one vector per cycle when OUT_READY is held high.
  - A full node takes 1 + DV + DV cycles minimum.
- sat_ACC clamps the accumulator to [-2^(ACC_BIT-1), 2^(ACC_BIT-1)-1].
- Only one node is in flight at a time; there are no overlapping handshakes across states.

Optional Feature:
- Macro: NBVN_POSTERIOR_EN.
- Defined:
  - Adds output port POST_LLR, width FIELD*LLR_BIT.
  - POST_LLR[e] = sat_LLR(ACC[e] - ACC[0]), registered and updated on the DEC_VALID cycle.
  - POST_LLR holds until the next DEC_VALID; it is 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
(defaults FIELD=3, LLR_BIT=3, DV=3, ACC_BIT=6; vectors written [e0,e1,e2])
- Reset: hold RST_N low 2 cycles with CH_VALID = 1 -> CH_VALID is not accepted while in reset. After release: CH_READY = 1, IN_READY = 0, OUT_VALID = 0, DEC_VALID = 0.
- Basic: CH [0,1,-1]; messages [0,1,0], [0,-2,1], [0,1,1]; OUT_READY = 1 -> DEC_SYM = 1, with DEC_VALID on the first EMIT cycle. Outputs are idx 0 [0,0,1], idx 1 [0,3,0], idx 2 with OUT_LAST [0,0,0], on 3 consecutive cycles.
- Normalization: CH [2,0,0]; three messages [0,0,0] -> each OUT_LLR = [0,-2,-2]; DEC_SYM = 0.
- Saturation: CH [0,3,-4]; three messages [0,3,-4] -> each OUT_LLR = [0,3,-4] (ext [0,9,-12] clamped); DEC_SYM = 1.
- Backpressure: OUT_READY low for 3 cycles at idx 1; CH_VALID and IN_VALID pulsed meanwhile -> OUT_LLR and OUT_IDX stay stable. IN_READY = CH_READY = 0. No extra handshakes; idx 2 follows once OUT_READY rises.
- Reset mid-EMIT: RST_N low for 1 cycle after the idx 0 handshake -> next cycle OUT_VALID = 0 and CH_READY = 1. A new node (Basic vectors) then produces correct outputs.

Source files
------------

// File: rtl/nbvn_llr_accum.sv
// nbvn_llr_accum: serial non-binary variable-node unit for the GF(q) LDPC decoder.
//
// Accepts one channel LLR vector and then DV check-to-variable messages, which
// arrive already de-permuted. It then emits DV extrinsic variable-to-check
// vectors, normalized to element 0 and saturated to LLR_BIT, and a
// hard-decision symbol. Only one node is in flight at a time.
//
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   ch_valid/ch_ready/ch_llr    channel LLR vector in (ready only in IDLE)
//   in_valid/in_ready/in_llr    C2V message in (ready only in ACCUM)
//   out_valid/out_ready/out_llr extrinsic V2C vector out
//   out_idx, out_last           edge index k of out_llr, high when k == DV-1
//   dec_valid, dec_sym          one-cycle hard-decision pulse and symbol
//   post_llr                    normalized posterior (only with NBVN_POSTERIOR_EN)
//
// Vector packing: element e sits at bits [e*LLR_BIT +: LLR_BIT], two's complement.
// Optional macro NBVN_POSTERIOR_EN adds the registered post_llr output.

module nbvn_llr_accum #(
    parameter int unsigned FIELD   = 3,
    parameter int unsigned LLR_BIT = 3,
    parameter int unsigned DV      = 3,
    parameter int unsigned ACC_BIT = 6,
    localparam int unsigned IDX_W  = (DV > 1) ? $clog2(DV) : 1,
    localparam int unsigned SYM_W  = (FIELD > 1) ? $clog2(FIELD) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ch_valid,
    output logic                     ch_ready,
    input  logic [FIELD*LLR_BIT-1:0] ch_llr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FIELD*LLR_BIT-1:0] in_llr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FIELD*LLR_BIT-1:0] out_llr,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
`ifdef NBVN_POSTERIOR_EN
    output logic [FIELD*LLR_BIT-1:0] post_llr,
`endif
    output logic                     dec_valid,
    output logic [SYM_W-1:0]         dec_sym
);

    typedef logic signed [LLR_BIT-1:0] llr_t;
    typedef logic signed [ACC_BIT-1:0] acc_t;
    typedef logic signed [ACC_BIT:0]   sum_t;
    typedef logic signed [ACC_BIT+1:0] ext_t;
    // One extra bit over ext_t so ext[e] - ext[0] cannot wrap before clamping.
    typedef logic signed [ACC_BIT+2:0] dif_t;

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_t;

    localparam sum_t ACC_HI = sum_t'((1 << (ACC_BIT - 1)) - 1);
    localparam sum_t ACC_LO = ~ACC_HI;
    localparam dif_t LLR_HI = dif_t'((1 << (LLR_BIT - 1)) - 1);
    localparam dif_t LLR_LO = ~LLR_HI;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DV - 1);

    function automatic acc_t sat_acc(input sum_t x);
        if (x > ACC_HI) begin
            return acc_t'(ACC_HI);
        end else if (x < ACC_LO) begin
            return acc_t'(ACC_LO);
        end
        return acc_t'(x);
    endfunction

    function automatic llr_t sat_llr(input dif_t x);
        if (x > LLR_HI) begin
            return llr_t'(LLR_HI);
        end else if (x < LLR_LO) begin
            return llr_t'(LLR_LO);
        end
        return llr_t'(x);
    endfunction

    state_t                   state_q;
    acc_t                     acc_q [FIELD];
    llr_t                     msg_q [DV][FIELD];
    logic [IDX_W-1:0]         cnt_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic [FIELD*LLR_BIT-1:0] out_llr_q;
    logic                     dec_valid_q;
    logic [SYM_W-1:0]         dec_sym_q;

    llr_t                     ch_e    [FIELD];
    llr_t                     in_e    [FIELD];
    acc_t                     acc_sum [FIELD];
    acc_t                     src_acc [FIELD];
    llr_t                     src_msg [FIELD];
    logic [IDX_W-1:0]         sel_k;
    ext_t                     ext0;
    ext_t                     ext_e;
    acc_t                     best_val;
    logic [SYM_W-1:0]         best_sym;
    logic [FIELD*LLR_BIT-1:0] emit_llr;

`ifdef NBVN_POSTERIOR_EN
    logic [FIELD*LLR_BIT-1:0] post_q;
    logic [FIELD*LLR_BIT-1:0] post_nxt;
`endif

    always_comb begin
        sel_k    = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        best_val = '0;
        best_sym = '0;
        ext0     = '0;
        ext_e    = '0;
        emit_llr = '0;
`ifdef NBVN_POSTERIOR_EN
        post_nxt = '0;
`endif
        for (int e = 0; e < FIELD; e++) begin
            ch_e[e]    = llr_t'(ch_llr[e*LLR_BIT +: LLR_BIT]);
            in_e[e]    = llr_t'(in_llr[e*LLR_BIT +: LLR_BIT]);
            acc_sum[e] = sat_acc(sum_t'(acc_q[e]) + sum_t'(in_e[e]));
            // In ACCUM the first output (k = 0) is prepared from the updated
            // accumulator; with DV == 1 its message is still on in_llr.
            src_acc[e] = (state_q == StAccum) ? acc_sum[e] : acc_q[e];
            if (state_q == StAccum) begin
                src_msg[e] = (cnt_q == '0) ? in_e[e] : msg_q[0][e];
            end else begin
                src_msg[e] = msg_q[sel_k][e];
            end
        end

        // argmax(ACC[e] - ACC[0]) == argmax(ACC[e]); strict > keeps lowest index on ties.
        best_val = acc_sum[0];
        for (int e = 1; e < FIELD; e++) begin
            if (acc_sum[e] > best_val) begin
                best_val = acc_sum[e];
                best_sym = SYM_W'(e);
            end
        end

        ext0 = ext_t'(src_acc[0]) - ext_t'(src_msg[0]);
        for (int e = 0; e < FIELD; e++) begin
            ext_e = ext_t'(src_acc[e]) - ext_t'(src_msg[e]);
            emit_llr[e*LLR_BIT +: LLR_BIT] = sat_llr(dif_t'(ext_e) - dif_t'(ext0));
`ifdef NBVN_POSTERIOR_EN
            post_nxt[e*LLR_BIT +: LLR_BIT] = sat_llr(dif_t'(acc_sum[e]) - dif_t'(acc_sum[0]));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_llr_q   <= '0;
            dec_valid_q <= 1'b0;
            dec_sym_q   <= '0;
            for (int e = 0; e < FIELD; e++) begin
                acc_q[e] <= '0;
            end
            for (int k = 0; k < DV; k++) begin
                for (int e = 0; e < FIELD; e++) begin
                    msg_q[k][e] <= '0;
                end
            end
`ifdef NBVN_POSTERIOR_EN
            post_q <= '0;
`endif
        end else begin
            dec_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ch_valid) begin
                        for (int e = 0; e < FIELD; e++) begin
                            acc_q[e] <= acc_t'(ch_e[e]);
                        end
                        cnt_q   <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        for (int e = 0; e < FIELD; e++) begin
                            msg_q[cnt_q][e] <= in_e[e];
                            acc_q[e]        <= acc_sum[e];
                        end
                        if (cnt_q == LAST) begin
                            cnt_q       <= '0;
                            state_q     <= StEmit;
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (DV == 1);
                            out_llr_q   <= emit_llr;
                            dec_valid_q <= 1'b1;
                            dec_sym_q   <= best_sym;
`ifdef NBVN_POSTERIOR_EN
                            post_q      <= post_nxt;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            idx_q       <= '0;
                            out_llr_q   <= '0;
                        end else begin
                            idx_q      <= sel_k;
                            out_last_q <= (sel_k == LAST);
                            out_llr_q  <= emit_llr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ch_ready  = (state_q == StIdle);
    assign in_ready  = (state_q == StAccum);
    assign out_valid = out_valid_q;
    assign out_llr   = out_llr_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;
    assign dec_valid = dec_valid_q;
    assign dec_sym   = dec_sym_q;
`ifdef NBVN_POSTERIOR_EN
    assign post_llr  = post_q;
`endif

endmodule

// File: tb/tb_nbvn_llr_accum.sv
// Self-checking bench for nbvn_llr_accum at default parameters.
// Expected outputs are pushed into queues when a node is issued; a monitor
// pops and compares on every output handshake and every dec_valid pulse.

module tb_nbvn_llr_accum;

    localparam int FIELD   = 3;
    localparam int LLR_BIT = 3;
    localparam int DV      = 3;
    localparam int ACC_BIT = 6;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ch_valid  = 1'b0;
    logic       ch_ready;
    logic [8:0] ch_llr    = '0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [8:0] in_llr    = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_llr;
    logic [1:0] out_idx;
    logic       out_last;
    logic       dec_valid;
    logic [1:0] dec_sym;
`ifdef NBVN_POSTERIOR_EN
    logic [8:0] post_llr;
`endif

    nbvn_llr_accum #(
        .FIELD  (FIELD),
        .LLR_BIT(LLR_BIT),
        .DV     (DV),
        .ACC_BIT(ACC_BIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_llr   (ch_llr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_llr   (in_llr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_llr  (out_llr),
        .out_idx  (out_idx),
        .out_last (out_last),
`ifdef NBVN_POSTERIOR_EN
        .post_llr (post_llr),
`endif
        .dec_valid(dec_valid),
        .dec_sym  (dec_sym)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
        logic [8:0] llr;
    } exp_t;

    exp_t       outq [$];
    logic [1:0] decq [$];
    int         checks   = 0;
    int         errors   = 0;
    logic       dec_prev = 1'b0;

    function automatic logic [8:0] pk(input int a, input int b, input int c);
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] z;
        x = 3'(a);
        y = 3'(b);
        z = 3'(c);
        return {z, y, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (outq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got idx %0d llr 0x%0h with nothing expected",
                         out_idx, out_llr);
            end else begin
                e = outq.pop_front();
                chk("out_llr", 32'(out_llr), 32'(e.llr));
                chk("out_idx", 32'(out_idx), 32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
        if (rst_n && dec_valid) begin
            if (decq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dec_unexpected: got sym %0d with nothing expected", dec_sym);
            end else begin
                chk("dec_sym", 32'(dec_sym), 32'(decq.pop_front()));
            end
            chk("dec_on_first_emit", {29'd0, out_valid, out_idx}, 32'h4);
            chk("dec_one_cycle", 32'(dec_prev), 32'h0);
        end
        dec_prev <= dec_valid;
    end

    task automatic send_ch(input logic [8:0] v);
        bit ok;
        ok       = 1'b0;
        ch_llr   = v;
        ch_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (ch_ready) ok = 1'b1;
            @(negedge clk);
        end
        ch_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ch_timeout: ch_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic send_in(input logic [8:0] v);
        bit ok;
        ok       = 1'b0;
        in_llr   = v;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_timeout: in_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    // Queue the expected outputs (first nexp of them), then drive the node.
    task automatic run_node(input logic [8:0] ch, input logic [8:0] m0, input logic [8:0] m1,
                            input logic [8:0] m2, input logic [8:0] o0, input logic [8:0] o1,
                            input logic [8:0] o2, input logic [1:0] sym, input int nexp);
        exp_t e;
        decq.push_back(sym);
        e.idx = 2'd0; e.last = 1'b0; e.llr = o0;
        outq.push_back(e);
        if (nexp > 1) begin
            e.idx = 2'd1; e.last = 1'b0; e.llr = o1;
            outq.push_back(e);
        end
        if (nexp > 2) begin
            e.idx = 2'd2; e.last = 1'b1; e.llr = o2;
            outq.push_back(e);
        end
        send_ch(ch);
        send_in(m0);
        send_in(m1);
        send_in(m2);
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (outq.size() == 0 && decq.size() == 0 && ch_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d outputs pending expected 0", name, outq.size());
            outq.delete();
            decq.delete();
        end
    endtask

    task automatic wait_idx0();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid && out_idx == 2'd0) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idx0_timeout: out_valid got 0 expected 1 within 20 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with ch_valid asserted: must not be accepted.
        rst_n    = 1'b0;
        ch_valid = 1'b1;
        ch_llr   = pk(1, 1, 1);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ch_valid = 1'b0;
        chk("rst_ch_ready", 32'(ch_ready), 32'h1);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_out_llr", 32'(out_llr), 32'h0);
        chk("rst_out_idx", 32'(out_idx), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_dec_sym", 32'(dec_sym), 32'h0);
        @(negedge clk);
        chk("idle_ch_ready", 32'(ch_ready), 32'h1);
        chk("idle_in_ready", 32'(in_ready), 32'h0);

        // Basic: ACC = [0,1,1], tie between 1 and 2 resolves to 1.
        run_node(pk(0, 1, -1), pk(0, 1, 0), pk(0, -2, 1), pk(0, 1, 1),
                 pk(0, 0, 1), pk(0, 3, 0), pk(0, 0, 0), 2'd1, 3);
        drain("basic");

        // Non-zero element 0 in messages: ACC = [2,1,-1], ext normalized by ext[0].
        run_node(pk(3, 0, -1), pk(1, 2, -3), pk(-2, 0, 1), pk(0, -1, 2),
                 pk(0, -2, 1), pk(0, -3, -4), pk(0, 0, -4), 2'd0, 3);
        drain("mixed");

        // Normalization.
        run_node(pk(2, 0, 0), pk(0, 0, 0), pk(0, 0, 0), pk(0, 0, 0),
                 pk(0, -2, -2), pk(0, -2, -2), pk(0, -2, -2), 2'd0, 3);
        drain("norm");

        // Saturation: ext [0,9,-12] clamps to [0,3,-4].
        run_node(pk(0, 3, -4), pk(0, 3, -4), pk(0, 3, -4), pk(0, 3, -4),
                 pk(0, 3, -4), pk(0, 3, -4), pk(0, 3, -4), 2'd1, 3);
        drain("sat");

        // Backpressure at idx 1 with stray ch_valid/in_valid pulses.
        run_node(pk(0, 1, -1), pk(0, 1, 0), pk(0, -2, 1), pk(0, 1, 1),
                 pk(0, 0, 1), pk(0, 3, 0), pk(0, 0, 0), 2'd1, 3);
        wait_idx0();
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        ch_valid = 1'b1;
        in_valid = 1'b1;
        ch_llr   = pk(1, 1, 1);
        in_llr   = pk(1, 1, 1);
        for (int j = 0; j < 3; j++) begin
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_idx", 32'(out_idx), 32'h1);
            chk("bp_out_llr", 32'(out_llr), 32'(pk(0, 3, 0)));
            chk("bp_out_last", 32'(out_last), 32'h0);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_ch_ready", 32'(ch_ready), 32'h0);
            if (j < 2) @(negedge clk);
        end
        ch_valid = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("bp");

        // Reset after the idx 0 handshake discards the rest of the node.
        run_node(pk(0, 1, -1), pk(0, 1, 0), pk(0, -2, 1), pk(0, 1, 1),
                 pk(0, 0, 1), pk(0, 3, 0), pk(0, 0, 0), 2'd1, 1);
        wait_idx0();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_ch_ready", 32'(ch_ready), 32'h1);
        chk("mrst_in_ready", 32'(in_ready), 32'h0);
        drain("mrst");

        run_node(pk(0, 1, -1), pk(0, 1, 0), pk(0, -2, 1), pk(0, 1, 1),
                 pk(0, 0, 1), pk(0, 3, 0), pk(0, 0, 0), 2'd1, 3);
        drain("post_rst");

        repeat (3) @(negedge clk);
        chk("final_idle_out_valid", 32'(out_valid), 32'h0);
        chk("final_queues_empty", 32'(outq.size() + decq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
